// File: rtl/tt_um_unload_if.sv
// Handshake and payload bundle for the weight readback transmitter.
// The slave side is the transmitter; the master side is the host/consumer.
interface tt_um_unload_if #(
    parameter int unsigned MAX_IN_LEN  = 16,
    parameter int unsigned MAX_OUT_LEN = 8
);
    logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] ui_weights;
    logic [6:0]                          ui_param;
    logic                                ui_start;
    logic                                ui_ready;
    logic [MAX_IN_LEN-1:0]               uo_data;
    logic                                uo_valid;
    logic                                uo_busy;
    logic                                uo_done;

    modport master (
        output ui_weights, ui_param, ui_start, ui_ready,
        input  uo_data, uo_valid, uo_busy, uo_done
    );

    modport slave (
        input  ui_weights, ui_param, ui_start, ui_ready,
        output uo_data, uo_valid, uo_busy, uo_done
    );
endinterface

// File: rtl/tt_um_unload.sv
// Serialises the packed 2-bit weight matrix column by column, MSB plane then LSB plane,
// with rows above the latched last-row index masked to zero.
module tt_um_unload #(
    parameter int unsigned MAX_IN_LEN  = 16,
    parameter int unsigned MAX_OUT_LEN = 8
) (
    input logic           clk,
    input logic           rst_n,
    tt_um_unload_if.slave io_bus
);
    localparam int unsigned MAX_OUT_BITS = (MAX_OUT_LEN > 1) ? $clog2(MAX_OUT_LEN) : 1;
    localparam int unsigned W_BITS       = 2 * MAX_IN_LEN * MAX_OUT_LEN;

    typedef enum logic [1:0] {StIdle, StMsb, StLsb, StDone} state_t;

    state_t                  r_state, w_state_nxt;
    logic [MAX_OUT_BITS-1:0] r_col, w_col_nxt;
    logic [MAX_OUT_BITS-1:0] r_last_col, w_last_col_nxt, w_col_clamped;
    logic [3:0]              r_last_row, w_last_row_nxt;
    logic [MAX_IN_LEN-1:0]   r_data, w_data_nxt;
    logic                    r_valid, w_valid_nxt;
    logic                    r_busy, w_busy_nxt;
    logic                    r_done, w_done_nxt;
    logic                    w_accept;

    function automatic logic [MAX_IN_LEN-1:0] f_plane(
        input logic [W_BITS-1:0]       weights,
        input logic [MAX_OUT_BITS-1:0] col,
        input logic                    msb,
        input logic [3:0]              last_row
    );
        logic [MAX_IN_LEN-1:0] plane;
        plane = '0;
        for (int i = 0; i < int'(MAX_IN_LEN); i++) begin
            if (i <= int'(last_row)) begin
                plane[i] = weights[2*(i*int'(MAX_OUT_LEN) + int'(col)) + int'(msb)];
            end
        end
        return plane;
    endfunction

    // Oversized column requests are clamped once, when the dump is latched.
    always_comb begin
        if (int'(io_bus.ui_param[2:0]) > int'(MAX_OUT_LEN) - 1) begin
            w_col_clamped = MAX_OUT_BITS'(MAX_OUT_LEN - 1);
        end else begin
            w_col_clamped = MAX_OUT_BITS'(io_bus.ui_param[2:0]);
        end
    end

    assign w_accept = r_valid & io_bus.ui_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_col_nxt      = r_col;
        w_last_col_nxt = r_last_col;
        w_last_row_nxt = r_last_row;
        w_data_nxt     = r_data;
        w_valid_nxt    = r_valid;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (io_bus.ui_start) begin
                    w_last_col_nxt = w_col_clamped;
                    w_last_row_nxt = io_bus.ui_param[6:3];
                    w_col_nxt      = '0;
                    w_data_nxt     = f_plane(io_bus.ui_weights, '0, 1'b1, io_bus.ui_param[6:3]);
                    w_valid_nxt    = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = StMsb;
                end
            end
            StMsb: begin
                if (w_accept) begin
                    w_data_nxt  = f_plane(io_bus.ui_weights, r_col, 1'b0, r_last_row);
                    w_state_nxt = StLsb;
                end
            end
            StLsb: begin
                if (w_accept) begin
                    if (r_col == r_last_col) begin
                        w_valid_nxt = 1'b0;
                        w_data_nxt  = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = StDone;
                    end else begin
                        w_col_nxt   = r_col + MAX_OUT_BITS'(1);
                        w_data_nxt  = f_plane(io_bus.ui_weights, r_col + MAX_OUT_BITS'(1), 1'b1,
                                              r_last_row);
                        w_state_nxt = StMsb;
                    end
                end
            end
            StDone: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_col      <= '0;
            r_last_col <= '0;
            r_last_row <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_last_col <= w_last_col_nxt;
            r_last_row <= w_last_row_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign io_bus.uo_data  = r_data;
    assign io_bus.uo_valid = r_valid;
    assign io_bus.uo_busy  = r_busy;
    assign io_bus.uo_done  = r_done;
endmodule

// File: tb/tb_tt_um_unload.sv
// Randomised self-checking bench for tt_um_unload against a beat-list reference model
// built from a 2-D weight array.
module tb_tt_um_unload;
    localparam int unsigned IN_LEN  = 16;
    localparam int unsigned OUT_LEN = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tt_um_unload_if #(.MAX_IN_LEN(IN_LEN), .MAX_OUT_LEN(OUT_LEN)) bus ();

    tt_um_unload #(.MAX_IN_LEN(IN_LEN), .MAX_OUT_LEN(OUT_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]        wt [IN_LEN][OUT_LEN];
    logic [IN_LEN-1:0] exp_q[$];
    logic [IN_LEN-1:0] got[$];
    int stall_errs, done_cnt, done_cyc, busy_fall_cyc;
    bit timed_out;

    task automatic apply_weights();
        for (int i = 0; i < int'(IN_LEN); i++)
            for (int j = 0; j < int'(OUT_LEN); j++)
                bus.ui_weights[2*(i*int'(OUT_LEN)+j) +: 2] = wt[i][j];
    endtask

    task automatic fill_random();
        for (int i = 0; i < int'(IN_LEN); i++)
            for (int j = 0; j < int'(OUT_LEN); j++)
                wt[i][j] = 2'($urandom_range(0, 3));
        apply_weights();
    endtask

    // Expected beats: per column, MSB plane then LSB plane, rows above r zeroed.
    task automatic build_expected(input int c, input int r);
        logic [IN_LEN-1:0] beat;
        exp_q.delete();
        for (int col = 0; col <= c; col++) begin
            for (int p = 1; p >= 0; p--) begin
                beat = '0;
                for (int i = 0; i < int'(IN_LEN); i++)
                    if (i <= r) beat[i] = wt[i][col][p];
                exp_q.push_back(beat);
            end
        end
    endtask

    // Called #1 after a rising edge while the DUT is idle.
    task automatic start_dump(input logic [6:0] p);
        bus.ui_param = p;
        bus.ui_start = 1'b1;
        @(posedge clk); #1;
        bus.ui_start = 1'b0;
    endtask

    // mode 0: ready high, 1: ready pattern 0,0,1, 2: random ready.
    task automatic collect(input int mode, input bit disturb);
        bit                prev_stall;
        bit                rdy;
        logic [IN_LEN-1:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        got.delete();
        stall_errs = 0; done_cnt = 0; done_cyc = -1; busy_fall_cyc = -1; timed_out = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (bus.uo_done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && bus.uo_busy === 1'b0) begin
                busy_fall_cyc = cyc;
                timed_out = 1'b0;
                break;
            end
            if (prev_stall && (bus.uo_valid !== 1'b1 || bus.uo_data !== prev_data)) stall_errs++;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 2);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (disturb && cyc == 5) begin
                bus.ui_start = 1'b1;
                bus.ui_param = 7'($urandom);
            end
            if (disturb && cyc == 6) bus.ui_start = 1'b0;
            bus.ui_ready = rdy;
            if (bus.uo_valid === 1'b1 && rdy) got.push_back(bus.uo_data);
            prev_stall = (bus.uo_valid === 1'b1) && !rdy;
            prev_data  = bus.uo_data;
            @(posedge clk); #1;
        end
        if (timed_out) begin
            n_checks++; n_fail++;
            $display("FAIL collect_timeout: done_cyc=%0d beats=%0d, required completion", done_cyc,
                     got.size());
        end
    endtask

    task automatic test_reset();
        bus.ui_weights = '0; bus.ui_param = '0; bus.ui_start = 1'b0; bus.ui_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        n_checks++; if (bus.uo_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.uo_valid); end
        n_checks++; if (bus.uo_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.uo_busy); end
        n_checks++; if (bus.uo_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.uo_done); end
        n_checks++; if (bus.uo_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.uo_data); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.uo_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", bus.uo_busy); end
    endtask

    task automatic test_full_dump();
        for (int i = 0; i < int'(IN_LEN); i++)
            for (int j = 0; j < int'(OUT_LEN); j++)
                wt[i][j] = (i == j) ? 2'b01 : ((i == j + 8) ? 2'b11 : 2'b00);
        apply_weights();
        build_expected(7, 15);
        start_dump(7'h7F);
        collect(0, 1'b0);
        n_checks++; if (got.size() != 16) begin n_fail++; $display("FAIL full_count: got %0d want 16", got.size()); end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            n_checks++;
            if (got[k] !== exp_q[k]) begin n_fail++; $display("FAIL full_beat%0d: got %h want %h", k, got[k], exp_q[k]); end
        end
        if (got.size() == 16) begin
            n_checks++; if (got[0] !== 16'h0100) begin n_fail++; $display("FAIL full_c0_msb: got %h want 0100", got[0]); end
            n_checks++; if (got[1] !== 16'h0101) begin n_fail++; $display("FAIL full_c0_lsb: got %h want 0101", got[1]); end
            n_checks++; if (got[14] !== 16'h8000) begin n_fail++; $display("FAIL full_c7_msb: got %h want 8000", got[14]); end
            n_checks++; if (got[15] !== 16'h8080) begin n_fail++; $display("FAIL full_c7_lsb: got %h want 8080", got[15]); end
        end
        n_checks++; if (done_cyc != 16) begin n_fail++; $display("FAIL full_done_cyc: got %0d want 16", done_cyc); end
        n_checks++; if (busy_fall_cyc != 17) begin n_fail++; $display("FAIL full_busy_fall: got %0d want 17", busy_fall_cyc); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL full_done_pulses: got %0d want 1", done_cnt); end
    endtask

    task automatic test_row_mask();
        for (int i = 0; i < int'(IN_LEN); i++)
            for (int j = 0; j < int'(OUT_LEN); j++)
                wt[i][j] = 2'b11;
        apply_weights();
        start_dump(7'h19);
        collect(0, 1'b0);
        n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL mask_count: got %0d want 4", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            n_checks++;
            if (got[k] !== 16'h000F) begin n_fail++; $display("FAIL mask_beat%0d: got %h want 000f", k, got[k]); end
        end
        n_checks++; if (done_cyc != 4) begin n_fail++; $display("FAIL mask_done_cyc: got %0d want 4", done_cyc); end
    endtask

    task automatic test_backpressure();
        fill_random();
        build_expected(7, 15);
        start_dump(7'h7F);
        collect(1, 1'b0);
        n_checks++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            n_checks++;
            if (got[k] !== exp_q[k]) begin n_fail++; $display("FAIL bp_beat%0d: got %h want %h", k, got[k], exp_q[k]); end
        end
        n_checks++; if (stall_errs != 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d changes want 0", stall_errs); end
        n_checks++; if (done_cyc != 48) begin n_fail++; $display("FAIL bp_done_cyc: got %0d want 48", done_cyc); end
    endtask

    task automatic test_start_while_busy();
        fill_random();
        build_expected(5, 9);
        start_dump(7'h4D);
        collect(2, 1'b1);
        n_checks++; if (got.size() != 12) begin n_fail++; $display("FAIL busy_count: got %0d want 12", got.size()); end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            n_checks++;
            if (got[k] !== exp_q[k]) begin n_fail++; $display("FAIL busy_beat%0d: got %h want %h", k, got[k], exp_q[k]); end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_done_pulses: got %0d want 1", done_cnt); end
        // Now idle, one cycle after the done pulse.
        build_expected(0, 0);
        start_dump(7'h00);
        n_checks++; if (bus.uo_valid !== 1'b1 || bus.uo_busy !== 1'b1) begin n_fail++; $display("FAIL restart_launch: valid=%b busy=%b want 1 1", bus.uo_valid, bus.uo_busy); end
        collect(0, 1'b0);
        n_checks++; if (got.size() != 2) begin n_fail++; $display("FAIL restart_count: got %0d want 2", got.size()); end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            n_checks++;
            if (got[k] !== exp_q[k]) begin n_fail++; $display("FAIL restart_beat%0d: got %h want %h", k, got[k], exp_q[k]); end
        end
    endtask

    task automatic test_reset_mid_dump();
        int dones;
        fill_random();
        build_expected(7, 15);
        bus.ui_ready = 1'b1;
        start_dump(7'h7F);
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.uo_valid !== 1'b0 || bus.uo_busy !== 1'b0 || bus.uo_data !== '0) begin
            n_fail++; $display("FAIL midrst_clear: valid=%b busy=%b data=%h want 0 0 0", bus.uo_valid, bus.uo_busy, bus.uo_data);
        end
        dones = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.uo_done === 1'b1) dones++;
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.uo_done === 1'b1) dones++;
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses want 0", dones); end
        start_dump(7'h7F);
        collect(0, 1'b0);
        n_checks++; if (got.size() != 16) begin n_fail++; $display("FAIL midrst_count: got %0d want 16", got.size()); end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            n_checks++;
            if (got[k] !== exp_q[k]) begin n_fail++; $display("FAIL midrst_beat%0d: got %h want %h", k, got[k], exp_q[k]); end
        end
    endtask

    task automatic test_loopback();
        logic [2*IN_LEN*OUT_LEN-1:0] recon;
        int col;
        fill_random();
        start_dump(7'h7F);
        collect(2, 1'b0);
        recon = '0;
        for (int k = 0; k < got.size(); k++) begin
            col = k / 2;
            if (col < int'(OUT_LEN))
                for (int i = 0; i < int'(IN_LEN); i++)
                    recon[2*(i*int'(OUT_LEN)+col) + ((k % 2 == 0) ? 1 : 0)] = got[k][i];
        end
        n_checks++; if (got.size() != 16) begin n_fail++; $display("FAIL loop_count: got %0d want 16", got.size()); end
        n_checks++; if (recon !== bus.ui_weights) begin n_fail++; $display("FAIL loop_weights: got %h want %h", recon, bus.ui_weights); end
    endtask

    task automatic test_random();
        int c, r, mode;
        for (int it = 0; it < 6; it++) begin
            fill_random();
            c    = $urandom_range(0, 7);
            r    = $urandom_range(0, 15);
            mode = $urandom_range(0, 2);
            build_expected(c, r);
            start_dump({4'(r), 3'(c)});
            collect(mode, 1'b0);
            n_checks++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_count: got %0d want %0d", it, got.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
                n_checks++;
                if (got[k] !== exp_q[k]) begin n_fail++; $display("FAIL rnd%0d_beat%0d: got %h want %h", it, k, got[k], exp_q[k]); end
            end
            n_checks++; if (done_cnt != 1 || stall_errs != 0) begin n_fail++; $display("FAIL rnd%0d_ctrl: done=%0d stalls=%0d want 1 0", it, done_cnt, stall_errs); end
        end
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_row_mask();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_dump();
        test_loopback();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
